// File: rtl/trace_frame_rx_if.sv
// trace_frame_rx_if
// Byte-level link between the frame receiver and a UART transmitter/receiver pair.
//   tx_dv / tx_byte : one-cycle request to transmit a byte (receiver -> UART)
//   tx_done         : one-cycle transmit completion pulse (UART -> receiver)
//   rx_dv / rx_byte : one-cycle received-byte strobe and data (UART -> receiver)
// The master modport is the frame receiver; the slave modport is the UART side.
interface trace_frame_rx_if;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       tx_done;
  logic       rx_dv;
  logic [7:0] rx_byte;

  modport master (output tx_dv, output tx_byte, input tx_done, input rx_dv, input rx_byte);
  modport slave  (input tx_dv, input tx_byte, output tx_done, output rx_dv, output rx_byte);
endinterface

// File: rtl/trace_frame_rx.sv
// trace_frame_rx
// Sends one command byte to a capture device, then receives a frame of
// plaintext (2N bits), key (N*M bits), ciphertext (2N bits) and SAMPLES trace
// bytes. Trace bytes go to an internal memory readable at any time; the first
// 0xFF trace byte is flagged as a marker. An inter-byte gap of TIMEOUT cycles
// while receiving abandons the frame with an err pulse.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   start, cmd_byte  : acquisition request and the command byte to send
//   uart             : tx/rx byte link (master side)
//   busy             : acquisition in progress
//   pt, key, ct      : received fields, MSB-first
//   rd_addr, rd_data : registered trace-memory read port
//   marker_found/pos : first 0xFF trace sample of the last frame
//   done, err        : one-cycle completion / timeout pulses
module trace_frame_rx #(
  parameter int N       = 16,
  parameter int M       = 4,
  parameter int SAMPLES = 1024,
  parameter int TIMEOUT = 1000000,
  localparam int AW     = $clog2(SAMPLES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [7:0]          cmd_byte,
  trace_frame_rx_if.master    uart,
  output logic                busy,
  output logic [2*N-1:0]      pt,
  output logic [N*M-1:0]      key,
  output logic [2*N-1:0]      ct,
  input  logic [AW-1:0]       rd_addr,
  output logic [7:0]          rd_data,
  output logic                marker_found,
  output logic [AW-1:0]       marker_pos,
  output logic                done,
  output logic                err
);

  localparam int PB   = (2 * N) / 8;
  localparam int KB   = (N * M) / 8;
  localparam int MAXB = (SAMPLES > KB) ? SAMPLES : KB;
  localparam int BCW  = $clog2(MAXB + 1);
  localparam int TCW  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD_SEND, S_CMD_WAIT, S_RX_PT, S_RX_KEY, S_RX_CT, S_RX_TRACE, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       cmd_q;
  logic [2*N-1:0]   pt_q;
  logic [N*M-1:0]   key_q;
  logic [2*N-1:0]   ct_q;
  logic             mfound_q;
  logic [AW-1:0]    mpos_q;
  logic [BCW-1:0]   bcnt_q;
  logic [TCW-1:0]   tcnt_q;
  logic             err_q;
  logic [7:0]       rd_data_q;
  logic [7:0]       mem [SAMPLES];

  logic in_rx, rx_take, enter_pt, byte_last, timeout_hit;

  assign in_rx    = (state_q == S_RX_PT) || (state_q == S_RX_KEY) ||
                    (state_q == S_RX_CT) || (state_q == S_RX_TRACE);
  assign rx_take  = in_rx && uart.rx_dv;
  assign enter_pt = (state_q == S_CMD_WAIT) && uart.tx_done;
  // A byte arriving on the expiry cycle wins over the timeout.
  assign timeout_hit = in_rx && !uart.rx_dv && (tcnt_q == TCW'(TIMEOUT - 1));

  always_comb begin
    byte_last = 1'b0;
    case (state_q)
      S_RX_PT:    byte_last = (bcnt_q == BCW'(PB - 1));
      S_RX_KEY:   byte_last = (bcnt_q == BCW'(KB - 1));
      S_RX_CT:    byte_last = (bcnt_q == BCW'(PB - 1));
      S_RX_TRACE: byte_last = (bcnt_q == BCW'(SAMPLES - 1));
      default:    byte_last = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (start) state_d = S_CMD_SEND;
      S_CMD_SEND: state_d = S_CMD_WAIT;
      S_CMD_WAIT: if (uart.tx_done) state_d = S_RX_PT;
      S_RX_PT:    if (timeout_hit) state_d = S_IDLE;
                  else if (rx_take && byte_last) state_d = S_RX_KEY;
      S_RX_KEY:   if (timeout_hit) state_d = S_IDLE;
                  else if (rx_take && byte_last) state_d = S_RX_CT;
      S_RX_CT:    if (timeout_hit) state_d = S_IDLE;
                  else if (rx_take && byte_last) state_d = S_RX_TRACE;
      S_RX_TRACE: if (timeout_hit) state_d = S_IDLE;
                  else if (rx_take && byte_last) state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy         = (state_q != S_IDLE) && (state_q != S_DONE);
    uart.tx_dv   = (state_q == S_CMD_SEND);
    uart.tx_byte = cmd_q;
    done         = (state_q == S_DONE);
    err          = err_q;
  end

  // Frame datapath: command latch, field shifters, counters, marker
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q    <= '0;
      pt_q     <= '0;
      key_q    <= '0;
      ct_q     <= '0;
      mfound_q <= 1'b0;
      mpos_q   <= '0;
      bcnt_q   <= '0;
      tcnt_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= timeout_hit;
      if ((state_q == S_IDLE) && start) cmd_q <= cmd_byte;

      if (enter_pt || rx_take || !in_rx) tcnt_q <= '0;
      else                               tcnt_q <= tcnt_q + 1'b1;

      // The byte counter restarts per field; after a timeout it is
      // cleared again when the next frame enters RX_PT.
      if (enter_pt)     bcnt_q <= '0;
      else if (rx_take) bcnt_q <= byte_last ? '0 : bcnt_q + 1'b1;

      if (enter_pt) begin
        mfound_q <= 1'b0;
        mpos_q   <= '0;
      end

      if (rx_take) begin
        case (state_q)
          S_RX_PT:  pt_q  <= {pt_q[2*N-9:0], uart.rx_byte};
          S_RX_KEY: key_q <= {key_q[N*M-9:0], uart.rx_byte};
          S_RX_CT:  ct_q  <= {ct_q[2*N-9:0], uart.rx_byte};
          S_RX_TRACE:
            if ((uart.rx_byte == 8'hFF) && !mfound_q) begin
              mfound_q <= 1'b1;
              mpos_q   <= bcnt_q[AW-1:0];
            end
          default: ;
        endcase
      end
    end
  end

  // Trace memory: not reset; read port is registered
  always_ff @(posedge clk) begin
    if (!rst && rx_take && (state_q == S_RX_TRACE)) mem[bcnt_q[AW-1:0]] <= uart.rx_byte;
    rd_data_q <= mem[rd_addr];
  end

  assign pt           = pt_q;
  assign key          = key_q;
  assign ct           = ct_q;
  assign marker_found = mfound_q;
  assign marker_pos   = mpos_q;
  assign rd_data      = rd_data_q;

endmodule

// File: tb/tb_trace_frame_rx.sv
module tb_trace_frame_rx;
  localparam int N       = 16;
  localparam int M       = 4;
  localparam int SAMPLES = 1024;
  localparam int TIMEOUT = 100;
  localparam int AW      = 10;
  localparam int HDR     = 16;
  localparam int FB      = HDR + SAMPLES;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [7:0]      cmd_byte = 8'h00;
  logic            busy;
  logic [2*N-1:0]  pt;
  logic [N*M-1:0]  key;
  logic [2*N-1:0]  ct;
  logic [AW-1:0]   rd_addr = '0;
  logic [7:0]      rd_data;
  logic            marker_found;
  logic [AW-1:0]   marker_pos;
  logic            done;
  logic            err;

  trace_frame_rx_if bus();

  trace_frame_rx #(.N(N), .M(M), .SAMPLES(SAMPLES), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .cmd_byte(cmd_byte), .uart(bus),
    .busy(busy), .pt(pt), .key(key), .ct(ct), .rd_addr(rd_addr), .rd_data(rd_data),
    .marker_found(marker_found), .marker_pos(marker_pos), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Edge counter and pulse monitors (sampled on the falling edge)
  int         cyc = 0;
  int         txdv_cnt = 0, done_cnt = 0, err_cnt = 0;
  int         err_edge = 0, last_rx_edge = 0;
  logic [7:0] last_tx = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.tx_dv) begin
      txdv_cnt <= txdv_cnt + 1;
      last_tx  <= bus.tx_byte;
    end
    if (done) done_cnt <= done_cnt + 1;
    if (err) begin
      err_cnt  <= err_cnt + 1;
      err_edge <= cyc;
    end
    if (bus.rx_dv) last_rx_edge <= cyc + 1;
  end

  // Reference model: frame bytes, expected fields, expected trace memory
  logic [7:0]      fb   [FB];
  logic [7:0]      tmem [SAMPLES];
  logic [7:0]      nom  [HDR] = '{8'h65, 8'h65, 8'h68, 8'h77,
                                  8'h19, 8'h18, 8'h11, 8'h10, 8'h09, 8'h08, 8'h01, 8'h00,
                                  8'hC6, 8'h9B, 8'hE9, 8'hBB};
  logic [2*N-1:0]  m_pt  = '0;
  logic [N*M-1:0]  m_key = '0;
  logic [2*N-1:0]  m_ct  = '0;
  logic            m_found = 1'b0;
  int              m_pos = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: nominal header, random trace without 0xFF
  // mode 1: random header, random trace with 0xFF only at 37 and 90
  // mode 2: random header, trace byte k = k mod 256
  task automatic fill_frame(input int mode);
    for (int i = 0; i < HDR; i++) fb[i] = (mode == 0) ? nom[i] : 8'($urandom);
    for (int k = 0; k < SAMPLES; k++) begin
      if (mode == 2) fb[HDR + k] = 8'(k % 256);
      else           fb[HDR + k] = 8'($urandom_range(0, 254));
    end
    if (mode == 1) begin
      fb[HDR + 37] = 8'hFF;
      fb[HDR + 90] = 8'hFF;
    end
  endtask

  // Byte idx of the frame is accepted: place it according to its position
  task automatic model_accept(input int idx);
    if (idx < 4)             m_pt  = (m_pt  * 256) + 32'(fb[idx]);
    else if (idx < 12)       m_key = (m_key * 256) + 64'(fb[idx]);
    else if (idx < HDR)      m_ct  = (m_ct  * 256) + 32'(fb[idx]);
    else begin
      tmem[idx - HDR] = fb[idx];
      if (fb[idx] == 8'hFF && !m_found) begin
        m_found = 1'b1;
        m_pos   = idx - HDR;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.rx_dv   = 1'b1;
    bus.rx_byte = b;
    tick();
    bus.rx_dv   = 1'b0;
    bus.rx_byte = 8'($urandom);
    repeat (gap) tick();
  endtask

  // slow: index after which the gap puts the next byte on the expiry cycle
  task automatic send_range(input int lo, input int hi, input int slow);
    for (int i = lo; i < hi; i++) begin
      send_byte(fb[i], (i == slow) ? TIMEOUT - 1 : int'($urandom_range(0, 2)));
      model_accept(i);
    end
  endtask

  task automatic begin_frame(input logic [7:0] cmd);
    m_found  = 1'b0;
    m_pos    = 0;
    start    = 1'b1;
    cmd_byte = cmd;
    tick();
    start    = 1'b0;
    cmd_byte = 8'h00;
    repeat (9) tick();
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
  endtask

  task automatic check_fields(input string tag);
    chk({tag, "_pt"},    64'(pt), 64'(m_pt));
    chk({tag, "_key"},   64'(key), 64'(m_key));
    chk({tag, "_ct"},    64'(ct), 64'(m_ct));
    chk({tag, "_mfound"}, 64'(marker_found), 64'(m_found));
    chk({tag, "_mpos"},  64'(marker_pos), 64'(m_pos));
  endtask

  task automatic check_read(input string tag, input int a);
    rd_addr = AW'(a);
    tick();
    chk(tag, 64'(rd_data), 64'(tmem[a]));
  endtask

  initial begin
    int t0, d0, e0;
    logic [7:0] c;
    bus.tx_done = 1'b0;
    bus.rx_dv   = 1'b0;
    bus.rx_byte = 8'h00;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_busy",   64'(busy), 64'd0);
    chk("rst_txdv",   64'(bus.tx_dv), 64'd0);
    chk("rst_txbyte", 64'(bus.tx_byte), 64'd0);
    chk("rst_done",   64'(done), 64'd0);
    chk("rst_err",    64'(err), 64'd0);
    check_fields("rst");

    // Bytes while idle are dropped
    send_byte(8'hAA, 0);
    send_byte(8'h55, 1);
    chk("idle_rx_pt",   64'(pt), 64'd0);
    chk("idle_rx_busy", 64'(busy), 64'd0);

    // Nominal frame
    fill_frame(0);
    t0 = txdv_cnt; d0 = done_cnt;
    begin_frame(8'h0F);
    chk("nom_busy",   64'(busy), 64'd1);
    chk("nom_txdv_n", 64'(txdv_cnt - t0), 64'd1);
    chk("nom_txbyte", 64'(last_tx), 64'h0F);
    send_range(0, FB, -1);
    repeat (3) tick();
    chk("nom_pt",     64'(pt), 64'h65656877);
    chk("nom_key",    64'(key), 64'h1918111009080100);
    chk("nom_ct",     64'(ct), 64'hC69BE9BB);
    chk("nom_done_n", 64'(done_cnt - d0), 64'd1);
    chk("nom_busy_after", 64'(busy), 64'd0);
    check_fields("nom");

    // Marker frame, with a stray start during the trace
    fill_frame(1);
    t0 = txdv_cnt; d0 = done_cnt;
    c = 8'($urandom);
    begin_frame(c);
    send_range(0, HDR + 200, -1);
    start = 1'b1; cmd_byte = 8'h5A;
    tick();
    start = 1'b0;
    send_range(HDR + 200, FB, -1);
    repeat (3) tick();
    chk("mk_txdv_n",   64'(txdv_cnt - t0), 64'd1);
    chk("mk_txbyte",   64'(last_tx), 64'(c));
    chk("mk_done_n",   64'(done_cnt - d0), 64'd1);
    chk("mk_found",    64'(marker_found), 64'd1);
    chk("mk_pos",      64'(marker_pos), 64'd37);
    check_fields("mk");
    for (int i = 0; i < 4; i++) check_read("mk_rd", int'($urandom_range(0, SAMPLES - 1)));

    // Readback frame: trace k mod 256
    fill_frame(2);
    begin_frame(8'($urandom));
    send_range(0, FB, -1);
    repeat (3) tick();
    check_fields("rb");
    rd_addr = AW'(300);
    tick();
    chk("rb_rd300", 64'(rd_data), 64'h2C);

    // Timeout after 5 key bytes
    fill_frame(1);
    e0 = err_cnt; d0 = done_cnt;
    begin_frame(8'($urandom));
    send_range(0, 9, -1);
    repeat (TIMEOUT + 50) tick();
    chk("to_err_n",    64'(err_cnt - e0), 64'd1);
    chk("to_latency",  64'(err_edge - last_rx_edge), 64'(TIMEOUT));
    chk("to_busy",     64'(busy), 64'd0);
    chk("to_done_n",   64'(done_cnt - d0), 64'd0);
    check_fields("to");

    // New start after timeout; one byte lands exactly on the expiry cycle
    fill_frame(1);
    t0 = txdv_cnt; e0 = err_cnt; d0 = done_cnt;
    begin_frame(8'($urandom));
    chk("bd_txdv_n", 64'(txdv_cnt - t0), 64'd1);
    send_range(0, FB, 6);
    repeat (3) tick();
    chk("bd_err_n",  64'(err_cnt - e0), 64'd0);
    chk("bd_done_n", 64'(done_cnt - d0), 64'd1);
    check_fields("bd");

    // Reset at trace byte 500, then a full frame
    fill_frame(1);
    d0 = done_cnt; e0 = err_cnt;
    begin_frame(8'($urandom));
    send_range(0, HDR + 500, -1);
    rst = 1'b1;
    tick();
    m_pt = '0; m_key = '0; m_ct = '0; m_found = 1'b0; m_pos = 0;
    chk("mr_busy",   64'(busy), 64'd0);
    chk("mr_txbyte", 64'(bus.tx_byte), 64'd0);
    chk("mr_done",   64'(done), 64'd0);
    chk("mr_err",    64'(err), 64'd0);
    check_fields("mr");
    rst = 1'b0;
    repeat (TIMEOUT + 20) tick();
    chk("mr_done_n", 64'(done_cnt - d0), 64'd0);
    chk("mr_err_n",  64'(err_cnt - e0), 64'd0);

    fill_frame(1);
    d0 = done_cnt;
    begin_frame(8'($urandom));
    send_range(0, FB, -1);
    repeat (3) tick();
    chk("af_done_n", 64'(done_cnt - d0), 64'd1);
    check_fields("af");
    for (int i = 0; i < 3; i++) check_read("af_rd", int'($urandom_range(0, SAMPLES - 1)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
